// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the single-port RAM Wishbone arbiter.
package spram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    typedef enum logic {
        GNT_IBUS = 1'b0,
        GNT_DBUS = 1'b1
    } grant_t;

    // Byte address to 32-bit word index.
    localparam int ADDR_SHIFT = 2;

endpackage

// File: rtl/spram_arb_sel.sv
// Two-request grant selector. SPRAM_ARB_RR_EN selects round-robin on contention,
// otherwise the data port has fixed priority.
module spram_arb_sel
    import spram_arb_pkg::*;
(
    input  logic ireq,
    input  logic dreq,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt
);

`ifndef SPRAM_ARB_RR_EN
    logic unused_last_gnt_s;
    assign unused_last_gnt_s = last_gnt;
`endif

    // Grant decision from the current requests
    always_comb begin
        gnt_valid = ireq | dreq;
        gnt       = GNT_IBUS;
`ifdef SPRAM_ARB_RR_EN
        if (ireq && dreq) begin
            if (last_gnt == GNT_IBUS) begin
                gnt = GNT_DBUS;
            end else begin
                gnt = GNT_IBUS;
            end
        end else if (dreq) begin
            gnt = GNT_DBUS;
        end else begin
            gnt = GNT_IBUS;
        end
`else
        if (dreq) begin
            gnt = GNT_DBUS;
        end else begin
            gnt = GNT_IBUS;
        end
`endif
    end

endmodule

// File: rtl/spram_wb_arbiter.sv
// Shares one single-port RAM between an instruction and a data Wishbone port.
// Optional SPRAM_ARB_RR_EN enables round-robin arbitration (default: data port priority).
module spram_wb_arbiter
    import spram_arb_pkg::*;
#(
    parameter  int MEMSIZE = 16384,
    localparam int AWIDTH  = $clog2(MEMSIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ibus_cyc,
    input  logic              ibus_stb,
    input  logic [31:0]       ibus_adr,
    output logic [31:0]       ibus_dat_r,
    output logic              ibus_ack,
    input  logic              dbus_cyc,
    input  logic              dbus_stb,
    input  logic              dbus_we,
    input  logic [31:0]       dbus_adr,
    input  logic [3:0]        dbus_sel,
    input  logic [31:0]       dbus_dat_w,
    output logic [31:0]       dbus_dat_r,
    output logic              dbus_ack,
    output logic              ram_rden,
    output logic              ram_wren,
    output logic [AWIDTH-1:0] ram_address,
    output logic [3:0]        ram_byteena,
    output logic [31:0]       ram_data,
    input  logic [31:0]       ram_q
);

    state_t state_r;
    state_t state_nxt_s;
    logic   ibus_ack_r;
    logic   dbus_ack_r;
    logic   ireq_s;
    logic   dreq_s;
    logic   gnt_valid_s;
    logic   gnt_s;
    logic   grant_now_s;
    logic   last_gnt_s;
    logic   unused_adr_s;

    assign ireq_s = ibus_cyc & ibus_stb;
    assign dreq_s = dbus_cyc & dbus_stb;
    // Reset gates the grant so the RAM is never touched while rst_n is low.
    assign grant_now_s = rst_n & gnt_valid_s & (state_r == IDLE);

    assign unused_adr_s = ^{ibus_adr[1:0], dbus_adr[1:0],
                            ibus_adr[31:AWIDTH+ADDR_SHIFT], dbus_adr[31:AWIDTH+ADDR_SHIFT]};

    spram_arb_sel u_sel (
        .ireq      (ireq_s),
        .dreq      (dreq_s),
        .last_gnt  (last_gnt_s),
        .gnt_valid (gnt_valid_s),
        .gnt       (gnt_s)
    );

`ifdef SPRAM_ARB_RR_EN
    logic last_gnt_r;

    // Remember the most recently granted port for round-robin fairness
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_r <= GNT_IBUS;
        end else if (grant_now_s) begin
            last_gnt_r <= gnt_s;
        end
    end

    assign last_gnt_s = last_gnt_r;
`else
    assign last_gnt_s = GNT_IBUS;
`endif

    // Next state and RAM command; RAM is only driven in the grant cycle
    always_comb begin
        state_nxt_s = state_r;
        ram_rden    = 1'b0;
        ram_wren    = 1'b0;
        ram_address = '0;
        ram_byteena = 4'h0;
        ram_data    = 32'h0;
        case (state_r)
            IDLE: begin
                if (grant_now_s) begin
                    state_nxt_s = ACK;
                    if (gnt_s == GNT_DBUS) begin
                        ram_address = dbus_adr[ADDR_SHIFT +: AWIDTH];
                        ram_rden    = ~dbus_we;
                        ram_wren    = dbus_we;
                        ram_byteena = dbus_we ? dbus_sel : 4'h0;
                        ram_data    = dbus_we ? dbus_dat_w : 32'h0;
                    end else begin
                        ram_address = ibus_adr[ADDR_SHIFT +: AWIDTH];
                        ram_rden    = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACK: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and ack registers; the ack flop captures the grant so it pulses in ACK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ibus_ack_r <= 1'b0;
            dbus_ack_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ibus_ack_r <= grant_now_s & (gnt_s == GNT_IBUS);
            dbus_ack_r <= grant_now_s & (gnt_s == GNT_DBUS);
        end
    end

    assign ibus_ack   = ibus_ack_r;
    assign dbus_ack   = dbus_ack_r;
    assign ibus_dat_r = ram_q;
    assign dbus_dat_r = ram_q;

endmodule
